// File: rtl/tc_result_restore.sv
// Restores signed products from unsigned Vedic-array magnitudes by negating lanes chunk-serially.
// Optional sign-flag output out_neg is compiled in with `define TC_RESTORE_FLAGS_EN.
module tc_result_restore #(
    parameter int CHUNK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_product,
    input  logic [3:0]  in_sign_a,
    input  logic [3:0]  in_sign_b,
    input  logic [1:0]  in_prec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result
`ifdef TC_RESTORE_FLAGS_EN
    ,
    output logic [3:0]  out_neg
`endif
);

    localparam int NCHUNK = 64 / CHUNK;
    localparam int CLOG   = $clog2(CHUNK);
    // One extra count value gives the cycle that transfers the finished word to the output.
    localparam int CW     = $clog2(NCHUNK) + 1;
    localparam logic [CW-1:0] CNT_END = CW'(NCHUNK);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [63:0]     prod_q;
    logic [63:0]     work_q;
    logic [63:0]     result_q;
    logic [3:0]      sign_a_q;
    logic [3:0]      sign_b_q;
    logic [1:0]      prec_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            out_valid_q;

    logic [5:0]      off;
    logic [1:0]      neg_idx;
    logic            lane_start;
    logic            chunk_neg;
    logic            carry_in;
    logic            carry_d;
    logic [CHUNK-1:0] chunk_raw;
    logic [CHUNK-1:0] chunk_d;
    logic [CHUNK:0]  neg_sum;
    logic            finish;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign finish     = (state_q == BUSY) && (cnt_q == CNT_END);

    // The sign selecting a lane's negation is always the one of the lane's top byte pair.
    always_comb begin
        off        = {cnt_q[CW-2:0], CLOG'(0)};
        chunk_raw  = prod_q[off +: CHUNK];
        neg_idx    = 2'd3;
        lane_start = 1'b0;
        case (prec_q)
            2'b00: begin
                neg_idx    = off[5:4];
                lane_start = (off[3:0] == 4'd0);
            end
            2'b01: begin
                neg_idx    = {off[5], 1'b1};
                lane_start = (off[4:0] == 5'd0);
            end
            default: begin
                neg_idx    = 2'd3;
                lane_start = (off == 6'd0);
            end
        endcase
        chunk_neg = sign_a_q[neg_idx] ^ sign_b_q[neg_idx];
        carry_in  = lane_start | carry_q;
        neg_sum   = {1'b0, ~chunk_raw} + {{CHUNK{1'b0}}, carry_in};
        chunk_d   = chunk_neg ? neg_sum[CHUNK-1:0] : chunk_raw;
        carry_d   = neg_sum[CHUNK];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prod_q      <= '0;
            sign_a_q    <= '0;
            sign_b_q    <= '0;
            prec_q      <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b1;
            work_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        prod_q   <= in_product;
                        sign_a_q <= in_sign_a;
                        sign_b_q <= in_sign_b;
                        prec_q   <= in_prec;
                        cnt_q    <= '0;
                        carry_q  <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        result_q    <= work_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        work_q[off +: CHUNK] <= chunk_d;
                        carry_q              <= carry_d;
                        cnt_q                <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef TC_RESTORE_FLAGS_EN
    logic [3:0] neg_flags;
    logic [3:0] out_neg_q;

    // Flag sits on the top 16b chunk of a negated lane with a nonzero magnitude.
    for (genvar gi = 0; gi < 4; gi++) begin : g_flag
        logic is_top;
        logic nz;
        assign is_top = (prec_q == 2'b00) ? 1'b1 :
                        (prec_q == 2'b01) ? ((gi % 2) == 1) : (gi == 3);
        assign nz     = (prec_q == 2'b00) ? (|prod_q[gi*16 +: 16]) :
                        (prec_q == 2'b01) ? (|prod_q[(gi/2)*32 +: 32]) : (|prod_q);
        assign neg_flags[gi] = is_top && nz && (sign_a_q[gi] ^ sign_b_q[gi]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_neg_q <= '0;
        end else if (finish) begin
            out_neg_q <= neg_flags;
        end
    end

    assign out_neg = out_neg_q;
`endif

endmodule

// File: tb/tb_tc_result_restore.sv
// Scoreboard bench for tc_result_restore (CHUNK=16): directed vectors, DONE hold and mid-BUSY reset.
module tb_tc_result_restore;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_product;
    logic [3:0]  in_sign_a;
    logic [3:0]  in_sign_b;
    logic [1:0]  in_prec;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
`ifdef TC_RESTORE_FLAGS_EN
    logic [3:0]  out_neg;
`endif

    tc_result_restore #(.CHUNK(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_sign_a  (in_sign_a),
        .in_sign_b  (in_sign_b),
        .in_prec    (in_prec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef TC_RESTORE_FLAGS_EN
        ,
        .out_neg    (out_neg)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int vec_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  neg;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard when out_valid rises, then checks the result stays held.
    logic        prev_v = 1'b0;
    logic [63:0] held   = '0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            chk("in_ready_low_while_valid", 64'(in_ready), 64'd0);
            if (!prev_v) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_out_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("result", out_result, mon_e.res);
                    chk("latency", 64'(cyc - mon_e.acc), 64'd5);
`ifdef TC_RESTORE_FLAGS_EN
                    chk("out_neg", 64'(out_neg), 64'(mon_e.neg));
`endif
                    $display("txn %0d: result=%h latency=%0d", mon_e.id, out_result, cyc - mon_e.acc);
                end
                held = out_result;
            end else begin
                chk("held_result", out_result, held);
            end
        end
        prev_v = (out_valid === 1'b1);
    end

    task automatic send(input logic [63:0] p, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [1:0] pr, input logic [63:0] res, input logic [3:0] ng,
                        input bit push);
        exp_t ex;
        int   n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", 64'(in_ready), 64'd1);
        in_product = p;
        in_sign_a  = sa;
        in_sign_b  = sb;
        in_prec    = pr;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vec_id++;
        if (push) begin
            ex.res = res;
            ex.neg = ng;
            ex.acc = cyc;
            ex.id  = vec_id;
            sb_q.push_back(ex);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_product = '0;
        in_sign_a  = '0;
        in_sign_b  = '0;
        in_prec    = '0;

        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_result", out_result, 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Directed vectors: product, sign_a, sign_b, prec, expected result, expected flags.
        send(64'h0019_0019_0019_0019, 4'b0101, 4'b0000, 2'b00, 64'h0019_FFE7_0019_FFE7, 4'b0101, 1'b1);
        drain();
        send(64'h0000_0000_0000_0001, 4'b1000, 4'b0000, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b1);
        drain();
        send(64'h0000_0003_0000_0000, 4'b1010, 4'b0000, 2'b01, 64'hFFFF_FFFD_0000_0000, 4'b1000, 1'b1);
        drain();
        send(64'h0000_0000_0001_0000, 4'b0000, 4'b1000, 2'b11, 64'hFFFF_FFFF_FFFF_0000, 4'b1000, 1'b1);
        drain();
        send(64'h1234_5678_9ABC_DEF0, 4'b1111, 4'b1111, 2'b00, 64'h1234_5678_9ABC_DEF0, 4'b0000, 1'b1);
        drain();
        send(64'h0000_0000_0000_0000, 4'b1111, 4'b0000, 2'b00, 64'h0000_0000_0000_0000, 4'b0000, 1'b1);
        drain();
        send(64'h8000_0001_FFFF_0000, 4'b1110, 4'b0000, 2'b00, 64'h8000_FFFF_0001_0000, 4'b1110, 1'b1);
        drain();
        send(64'h0000_0001_0000_0005, 4'b0011, 4'b0000, 2'b01, 64'h0000_0001_FFFF_FFFB, 4'b0010, 1'b1);
        drain();
        send(64'h0000_0000_FFFF_FFFF, 4'b0111, 4'b0000, 2'b10, 64'h0000_0000_FFFF_FFFF, 4'b0000, 1'b1);
        drain();

        // Back-pressure in DONE while in_valid toggles with fresh data.
        out_ready = 1'b0;
        send(64'h0000_0000_0000_00FF, 4'b0001, 4'b0000, 2'b00, 64'h0000_0000_0000_FF01, 4'b0001, 1'b1);
        begin
            int n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("hold_out_valid_seen", 64'(out_valid), 64'd1);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid   = (i % 2 == 0);
            in_product = 64'hDEAD_BEEF_0000_0000 + 64'(i);
            in_sign_a  = 4'b1111;
            @(negedge clk);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_second_capture", 64'(in_ready), 64'd1);
        end

        // Reset two cycles into BUSY: pending result discarded, outputs clear at once.
        send(64'h0000_0000_0000_0007, 4'b0001, 4'b0000, 2'b00, 64'h0, 4'b0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("busy_reset_out_valid", 64'(out_valid), 64'd0);
        chk("busy_reset_out_result", out_result, 64'd0);
        chk("busy_reset_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("busy_reset_in_ready_release", 64'(in_ready), 64'd1);
        repeat (12) @(negedge clk);
        chk("no_stale_out_valid", 64'(out_valid), 64'd0);

        send(64'h0000_0000_0000_0002, 4'b0000, 4'b1000, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tc_result_restore.md
TC_RESULT_RESTORE -- requirements
Module: tc_result_restore

Interface
REQ-001 The block SHALL have parameter CHUNK, default 16, giving the bits negated per cycle; legal values are 8 and 16, and NCHUNK = 64/CHUNK.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: the input beat is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept an input beat.
REQ-007 Port in_product, input, 64 bits: unsigned magnitude products from the Vedic array.
REQ-008 Port in_sign_a and in_sign_b, input, 4 bits each: per-byte operand sign bits, as captured before operand two's complement.
REQ-009 Port in_prec, input, 2 bits: operand precision; 00 = 8b, 01 = 16b, 10 = 32b, 11 = treated as 32b.
REQ-010 Port out_valid, output, 1 bit: the result is valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port out_result, output, 64 bits: signed products.

Function
REQ-013 Lane mapping SHALL follow in_prec:
- 00: four 16b lanes k=0..3; lane k is negated iff sign_a[k]^sign_b[k].
- 01: two 32b lanes j=0..1; lane j is negated iff sign_a[2j+1]^sign_b[2j+1].
- 10 or 11: one 64b lane, negated iff sign_a[3]^sign_b[3].
REQ-014 Negation SHALL be exact two's complement modulo the lane width; non-negated lanes SHALL pass through unchanged.
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE; in_ready SHALL equal (state==IDLE) && !rst.
REQ-016 In IDLE with in_valid=1, the block SHALL capture in_product, the sign bits and in_prec, clear the chunk counter, set the carry, and go to BUSY.
REQ-017 BUSY SHALL process one CHUNK per cycle, least significant chunk first, using a registered inter-chunk carry.
REQ-018 The carry SHALL be forced to 1 at every lane start, so no carry crosses a lane boundary, including the carry out of a zero lane.
REQ-019 After chunk NCHUNK-1 the block SHALL enter DONE with out_valid=1; out_valid SHALL rise NCHUNK+1 edges after the accepting edge (5 for CHUNK=16).
REQ-020 In DONE, out_result SHALL be held stable until out_valid && out_ready; on that edge the block SHALL return to IDLE.
REQ-021 in_ready SHALL be 0 while out_valid=1, so input and output never handshake in the same cycle.
REQ-022 in_valid SHALL be ignored outside IDLE, and captured inputs SHALL NOT change during BUSY or DONE.

Reset
REQ-023 Asserting rst at any time SHALL force IDLE, chunk counter=0, carry=1, out_valid=0 and out_result=0 (and out_neg=0 when compiled in).
REQ-024 Reset in BUSY or DONE SHALL discard the partial or pending result, and no out_valid SHALL follow.
REQ-025 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-026 Macro TC_RESTORE_FLAGS_EN SHALL control an optional sign-flag output.
REQ-027 With the macro defined, the block SHALL add output out_neg[3:0]; bit k SHALL be 1 iff 16b chunk k is the top chunk of a negated lane whose magnitude is nonzero, and it SHALL be valid with out_valid.
REQ-028 Without the macro, the out_neg port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (CHUNK=16)
REQ-029 Bench: prec=00, product=0x0019_0019_0019_0019, sign_a=0101, sign_b=0000 -> out_result=0x0019_FFE7_0019_FFE7, with out_valid 5 edges after accept.
REQ-030 Bench: prec=10, product=0x0000_0000_0000_0001, sign_a=1000, sign_b=0000 -> out_result=0xFFFF_FFFF_FFFF_FFFF, proving carry across all chunks.
REQ-031 Bench: prec=01, product=0x0000_0003_0000_0000, sign_a=1010, sign_b=0000 -> out_result=0xFFFF_FFFD_0000_0000, proving no carry leaks from the zero lane 0.
REQ-032 Bench: hold out_ready=0 for 10 cycles in DONE while toggling in_valid -> out_result and out_valid stable, in_ready=0, and no second capture.
REQ-033 Bench: assert rst two cycles into BUSY -> out_valid=0 and out_result=0 immediately, in_ready=1 after release, and no stale result.
REQ-034 Bench: with TC_RESTORE_FLAGS_EN, REQ-029 stimulus -> out_neg=0101 and REQ-030 stimulus -> out_neg=1000; without the macro the build has no out_neg.
